sdram_ctrl_fsm: RTL and testbench
=================================

SDRAM_CTRL_FSM -- requirements
Module: sdram_ctrl_fsm

Interface
REQ-001 SHALL have parameter INIT_WAIT, default 20000: power-up wait in clk cycles (200 us at 100 MHz).
REQ-002 SHALL have parameter REF_PERIOD, default 1560: auto-refresh interval in clk cycles (15.6 us).
REQ-003 SHALL have port clk  in  1  system clock; this block uses one clock.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port sdram_wr_req  in  1  write burst request, level, held until sdram_wr_ack is seen.
REQ-006 SHALL have port sdram_rd_req  in  1  read burst request, level, held until sdram_rd_ack is seen.
REQ-007 SHALL have port sdram_wr_burst  in  9  write burst length in words, legal range 1..256.
REQ-008 SHALL have port sdram_rd_burst  in  9  read burst length in words, legal range 4..256.
REQ-009 SHALL have port sdram_wr_ack  out  1  high on each cycle a write data word is consumed.
REQ-010 SHALL have port sdram_rd_ack  out  1  high on each cycle a read data word is valid on the DQ bus.
REQ-011 SHALL have port sdram_init_done  out  1  high while init_state == I_DONE.
REQ-012 SHALL have port init_state  out  5  current initialisation state, encoded per package.
REQ-013 SHALL have port work_state  out  4  current work state, encoded per package.
REQ-014 SHALL have port cnt_clk  out  10  cycles spent in current state, starting at 0.
REQ-015 SHALL have port sdram_rd_wr  out  1  selected access direction: 1 = read, 0 = write.

Function
REQ-016 cnt_clk SHALL clear to 0 on the cycle after any init_state or work_state change, else increment by 1, wrapping at 1023.
REQ-017 Init sequence SHALL be:
- I_NOP until the power-up counter reaches INIT_WAIT.
- I_PRE for 1 cycle.
- I_TRP for TRP_CLK cycles.
- I_AR for 1 cycle.
- I_TRF for TRC_CLK cycles.
REQ-018 From I_TRF, the FSM SHALL return to I_AR until AR_TIMES (8) refreshes have completed, then go to I_MRS (1 cycle), I_TRSC (TRSC_CLK cycles), then I_DONE.
REQ-019 work_state SHALL remain W_IDLE until I_DONE.
REQ-020 A refresh timer SHALL count while init_state == I_DONE and SHALL set an internal ref_req flag when it reaches REF_PERIOD.
REQ-021 The refresh timer SHALL restart from 0 on entry to W_AR, which also clears ref_req.
REQ-022 W_IDLE arbitration SHALL be: ref_req first, then sdram_wr_req, then sdram_rd_req.
REQ-023 Simultaneous requests SHALL be served one per idle visit, in the priority of REQ-022.
REQ-024 Write path SHALL be: W_ACTIVE (1 cycle), W_TRCD (TRCD_CLK), W_WRITE (1), W_WD, W_TWR (TWR_CLK), W_PRE (1), W_TRP (TRP_CLK), W_IDLE.
REQ-025 W_WD SHALL exit when end_wrburst (cnt_clk == sdram_wr_burst-1) is true.
REQ-026 sdram_wr_ack SHALL be high in W_WRITE and in W_WD while cnt_clk < sdram_wr_burst-1, giving exactly sdram_wr_burst ack cycles.
REQ-027 Read path SHALL be: W_ACTIVE, W_TRCD, W_READ (1), W_CL (TCL_CLK-1), W_RD, W_PRE, W_TRP, W_IDLE.
REQ-028 W_RD SHALL last exactly sdram_rd_burst cycles, and sdram_rd_ack SHALL be high throughout W_RD.
REQ-029 end_rdburst SHALL be (W_RD and cnt_clk == sdram_rd_burst-4).
REQ-030 Refresh path SHALL be: W_AR (1 cycle), W_TRFC (TRC_CLK), W_IDLE.
REQ-031 sdram_rd_wr SHALL be updated only when W_IDLE leaves for W_ACTIVE (0 for write, 1 for read) and SHALL be held otherwise.
REQ-032 A refresh expiring mid-burst SHALL be deferred, never aborting the burst; ref_req SHALL stay set until serviced.
REQ-033 A sdram_wr_burst value of 0 SHALL be treated as 1.
REQ-034 Requests SHALL be sampled only in W_IDLE; request level changes in other states SHALL be ignored.

Reset
REQ-035 On rst_n low, outputs SHALL be: init_state I_NOP, work_state W_IDLE, cnt_clk 0, acks 0, sdram_init_done 0, sdram_rd_wr 1.
REQ-036 On rst_n low, all internal counters SHALL clear; reset mid-operation SHALL restart the full INIT_WAIT sequence.

Structure
REQ-037 A shared package SHALL hold: I_*/W_* encodings, TRP_CLK=4, TRC_CLK=6, TRSC_CLK=6, TRCD_CLK=2, TCL_CLK=3, TWR_CLK=2, AR_TIMES=8, and the end_wrburst/end_rdburst definitions; the downstream command stage reuses these definitions.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 After reset: 20000 cycles in I_NOP, then 8 I_AR visits, I_MRS, then sdram_init_done=1.
REQ-040 wr_req with burst=256: exactly 256 wr_ack cycles, W_WD exits at cnt_clk=255, then W_TWR→W_PRE→W_TRP→W_IDLE.
REQ-041 rd_req with burst=8: W_RD begins 3 cycles after W_READ, 8 rd_ack cycles, end_rdburst at cnt_clk=4.
REQ-042 wr_req, rd_req and ref_req in the same idle cycle: service order is W_AR, then write, then read; sdram_rd_wr=0, then 1.
REQ-043 Refresh expiring during a 256-word write: the burst completes uncut and W_AR is the next state after W_IDLE.
REQ-044 rst_n asserted in W_WD: all outputs return to reset values immediately, and the init sequence restarts.

Source files
------------

// File: rtl/sdram_ctrl_fsm_pkg.sv
// Shared SDRAM controller encodings, timing constants and burst-end helpers.
// The downstream command stage imports these so both sides agree on burst ends.
package sdram_ctrl_fsm_pkg;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_state_t;

  localparam int TRP_CLK  = 4;
  localparam int TRC_CLK  = 6;
  localparam int TRSC_CLK = 6;
  localparam int TRCD_CLK = 2;
  localparam int TCL_CLK  = 3;
  localparam int TWR_CLK  = 2;
  localparam int AR_TIMES = 8;

  // Last cnt_clk value of W_WD; a zero burst behaves as a single word.
  function automatic logic [9:0] wr_last_cnt(input logic [8:0] burst);
    logic [8:0] eff;
    eff = (burst == 9'd0) ? 9'd1 : burst;
    return {1'b0, eff - 9'd1};
  endfunction

  function automatic logic end_wrburst(input logic [9:0] cnt, input logic [8:0] burst);
    return cnt == wr_last_cnt(burst);
  endfunction

  // Fires early enough for a precharge to land just after the last read word.
  function automatic logic end_rdburst(input work_state_t ws, input logic [9:0] cnt,
                                       input logic [8:0] burst);
    return (ws == W_RD) && (cnt == {1'b0, burst - 9'd4});
  endfunction

endpackage

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM controller sequencing: power-up init, then refresh/write/read arbitration.
// State is exported together with a per-state cycle counter for the command stage.
module sdram_ctrl_fsm
  import sdram_ctrl_fsm_pkg::*;
#(
  parameter int INIT_WAIT  = 20000,
  parameter int REF_PERIOD = 1560
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [8:0]  sdram_wr_burst,
  input  logic [8:0]  sdram_rd_burst,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        sdram_init_done,
  output init_state_t init_state,
  output work_state_t work_state,
  output logic [9:0]  cnt_clk,
  output logic        sdram_rd_wr
);

  localparam int PW = $clog2(INIT_WAIT + 1);
  localparam int RW = $clog2(REF_PERIOD + 1);
  localparam int AW = $clog2(AR_TIMES + 1);

  init_state_t   init_nxt;
  work_state_t   work_nxt;
  logic [PW-1:0] pwr_cnt;
  logic [RW-1:0] ref_cnt;
  logic [AW-1:0] ar_cnt;
  logic          ref_req;
  logic          init_done;
  logic [9:0]    wr_last;
  logic [9:0]    rd_last;

  assign init_done       = (init_state == I_DONE);
  assign sdram_init_done = init_done;
  assign wr_last         = wr_last_cnt(sdram_wr_burst);
  assign rd_last         = {1'b0, sdram_rd_burst - 9'd1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state  <= I_NOP;
      work_state  <= W_IDLE;
      cnt_clk     <= '0;
      pwr_cnt     <= '0;
      ar_cnt      <= '0;
      ref_cnt     <= '0;
      ref_req     <= 1'b0;
      sdram_rd_wr <= 1'b1;
    end else begin
      init_state <= init_nxt;
      work_state <= work_nxt;
      cnt_clk    <= (init_nxt != init_state || work_nxt != work_state) ? '0 : cnt_clk + 10'd1;
      if (init_state == I_NOP) pwr_cnt <= pwr_cnt + PW'(1);
      if (init_state == I_AR)  ar_cnt  <= ar_cnt + AW'(1);
      // Write wins arbitration, so a pending write decides the direction.
      if (work_state == W_IDLE && work_nxt == W_ACTIVE) sdram_rd_wr <= !sdram_wr_req;
      if (work_state != W_AR && work_nxt == W_AR) begin
        ref_cnt <= '0;
        ref_req <= 1'b0;
      end else if (init_done) begin
        if (ref_cnt == RW'(REF_PERIOD)) ref_req <= 1'b1;
        else                            ref_cnt <= ref_cnt + RW'(1);
      end
    end
  end

  always_comb begin
    init_nxt = init_state;
    case (init_state)
      I_NOP:   if (pwr_cnt == PW'(INIT_WAIT - 1)) init_nxt = I_PRE;
      I_PRE:   init_nxt = I_TRP;
      I_TRP:   if (cnt_clk == 10'(TRP_CLK - 1)) init_nxt = I_AR;
      I_AR:    init_nxt = I_TRF;
      I_TRF:   if (cnt_clk == 10'(TRC_CLK - 1))
                 init_nxt = (ar_cnt == AW'(AR_TIMES)) ? I_MRS : I_AR;
      I_MRS:   init_nxt = I_TRSC;
      I_TRSC:  if (cnt_clk == 10'(TRSC_CLK - 1)) init_nxt = I_DONE;
      default: init_nxt = init_state;
    endcase
  end

  // Work FSM is frozen in W_IDLE until init completes; requests only matter in W_IDLE.
  always_comb begin
    work_nxt     = work_state;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    if (init_done) begin
      case (work_state)
        W_IDLE:   if (ref_req)                         work_nxt = W_AR;
                  else if (sdram_wr_req || sdram_rd_req) work_nxt = W_ACTIVE;
        W_ACTIVE: work_nxt = W_TRCD;
        W_TRCD:   if (cnt_clk == 10'(TRCD_CLK - 1)) work_nxt = sdram_rd_wr ? W_READ : W_WRITE;
        W_READ:   work_nxt = W_CL;
        W_CL:     if (cnt_clk == 10'(TCL_CLK - 2)) work_nxt = W_RD;
        W_RD: begin
          sdram_rd_ack = 1'b1;
          if (cnt_clk == rd_last) work_nxt = W_PRE;
        end
        W_WRITE: begin
          sdram_wr_ack = 1'b1;
          work_nxt     = W_WD;
        end
        W_WD: begin
          sdram_wr_ack = (cnt_clk < wr_last);
          if (end_wrburst(cnt_clk, sdram_wr_burst)) work_nxt = W_TWR;
        end
        W_TWR:    if (cnt_clk == 10'(TWR_CLK - 1)) work_nxt = W_PRE;
        W_PRE:    work_nxt = W_TRP;
        W_TRP:    if (cnt_clk == 10'(TRP_CLK - 1)) work_nxt = W_IDLE;
        W_AR:     work_nxt = W_TRFC;
        W_TRFC:   if (cnt_clk == 10'(TRC_CLK - 1)) work_nxt = W_IDLE;
        default:  work_nxt = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_fsm.sv
// Directed bench for sdram_ctrl_fsm: init timing, write/read bursts,
// refresh deferral and priority, and reset in the middle of a write burst.
module tb_sdram_ctrl_fsm;
  import sdram_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdram_wr_req = 1'b0;
  logic        sdram_rd_req = 1'b0;
  logic [8:0]  sdram_wr_burst = 9'd256;
  logic [8:0]  sdram_rd_burst = 9'd8;
  logic        sdram_wr_ack, sdram_rd_ack, sdram_init_done, sdram_rd_wr;
  init_state_t init_state;
  work_state_t work_state;
  logic [9:0]  cnt_clk;

  sdram_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_init_done(sdram_init_done), .init_state(init_state),
    .work_state(work_state), .cnt_clk(cnt_clk), .sdram_rd_wr(sdram_rd_wr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_acks = 0, rd_acks = 0, ar_visits = 0, mrs_seen = 0;
  int wd_exit_cnt = -1, er_cnt = -1, prev_cnt = 0;
  work_state_t last_ws = W_IDLE;
  init_state_t last_is = I_NOP;
  work_state_t ws_log[$];
  int          ws_cyc[$];
  work_state_t svc_ws[$];
  logic        svc_rw[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: sample #1 after the edge and update the transition logs.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (sdram_wr_ack) wr_acks++;
    if (sdram_rd_ack) rd_acks++;
    if (end_rdburst(work_state, cnt_clk, sdram_rd_burst)) er_cnt = int'(cnt_clk);
    if (init_state != last_is) begin
      if (init_state == I_AR)  ar_visits++;
      if (init_state == I_MRS) mrs_seen++;
      last_is = init_state;
    end
    if (work_state != last_ws) begin
      ws_log.push_back(work_state);
      ws_cyc.push_back(cyc);
      if (last_ws == W_WD) wd_exit_cnt = prev_cnt;
      if (last_ws == W_IDLE) begin
        svc_ws.push_back(work_state);
        svc_rw.push_back(sdram_rd_wr);
      end
      last_ws = work_state;
    end
    prev_cnt = int'(cnt_clk);
  endtask

  task automatic wait_ws(input work_state_t t, input int budget, input string tag);
    int n = 0;
    while (work_state != t && n < budget) begin tick(); n++; end
    chk(tag, 32'(work_state), 32'(t));
  endtask

  task automatic do_write(input logic [8:0] b);
    int n = 0;
    sdram_wr_burst = b;
    sdram_wr_req = 1'b1;
    while (!sdram_wr_ack && n < 100) begin tick(); n++; end
    sdram_wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] b);
    int n = 0;
    sdram_rd_burst = b;
    sdram_rd_req = 1'b1;
    while (!sdram_rd_ack && n < 100) begin tick(); n++; end
    sdram_rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_init_state"}, 32'(init_state), 32'(I_NOP));
    chk({tag, "_work_state"}, 32'(work_state), 32'(W_IDLE));
    chk({tag, "_cnt_clk"}, 32'(cnt_clk), 0);
    chk({tag, "_wr_ack"}, 32'(sdram_wr_ack), 0);
    chk({tag, "_rd_ack"}, 32'(sdram_rd_ack), 0);
    chk({tag, "_init_done"}, 32'(sdram_init_done), 0);
    chk({tag, "_rd_wr"}, 32'(sdram_rd_wr), 1);
  endtask

  // Release reset, then expect INIT_WAIT cycles of I_NOP and a 68-cycle init tail.
  task automatic run_init(input string tag);
    int n = 0;
    int c0;
    ar_visits = 0;
    mrs_seen = 0;
    @(negedge clk) rst_n = 1'b1;
    do begin tick(); n++; end while (init_state == I_NOP && n < 30000);
    chk({tag, "_nop_cycles"}, n, 20000);
    chk({tag, "_pre_cnt"}, 32'(cnt_clk), 0);
    c0 = cyc;
    n = 0;
    while (!sdram_init_done && n < 500) begin tick(); n++; end
    chk({tag, "_init_done"}, 32'(sdram_init_done), 1);
    chk({tag, "_init_len"}, cyc - c0, 68);
    chk({tag, "_ar_visits"}, ar_visits, 8);
    chk({tag, "_mrs_seen"}, mrs_seen, 1);
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < ws_log.size()) return 32'(ws_log[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < ws_cyc.size()) return ws_cyc[i];
    return -100000;
  endfunction

  initial begin
    int base;
    int sbase;
    work_state_t wpath[8];
    work_state_t rpath[8];
    wpath = '{W_ACTIVE, W_TRCD, W_WRITE, W_WD, W_TWR, W_PRE, W_TRP, W_IDLE};
    rpath = '{W_ACTIVE, W_TRCD, W_READ, W_CL, W_RD, W_PRE, W_TRP, W_IDLE};

    repeat (3) tick();
    check_reset_outputs("reset");

    run_init("init");
    chk("idle_during_init", ws_log.size(), 0);

    // 256-word write
    base = ws_log.size();
    wr_acks = 0;
    do_write(9'd256);
    wait_ws(W_IDLE, 400, "wr256_done");
    chk("wr256_acks", wr_acks, 256);
    chk("wr256_wd_exit_cnt", wd_exit_cnt, 255);
    for (int k = 0; k < 8; k++) chk($sformatf("wr256_path%0d", k), log_at(base + k), 32'(wpath[k]));
    chk("wr256_wd_len", cyc_at(base + 4) - cyc_at(base + 3), 256);
    chk("wr256_twr_len", cyc_at(base + 5) - cyc_at(base + 4), 2);
    chk("wr256_rd_wr", 32'(sdram_rd_wr), 0);

    // zero-length write behaves as one word
    wr_acks = 0;
    do_write(9'd0);
    wait_ws(W_IDLE, 100, "wr0_done");
    chk("wr0_acks", wr_acks, 1);
    chk("wr0_wd_exit_cnt", wd_exit_cnt, 0);

    // 8-word read
    base = ws_log.size();
    rd_acks = 0;
    er_cnt = -1;
    do_read(9'd8);
    wait_ws(W_IDLE, 100, "rd8_done");
    chk("rd8_acks", rd_acks, 8);
    chk("rd8_end_rdburst_cnt", er_cnt, 4);
    chk("rd8_rd_wr", 32'(sdram_rd_wr), 1);
    for (int k = 0; k < 8; k++) chk($sformatf("rd8_path%0d", k), log_at(base + k), 32'(rpath[k]));
    chk("rd8_cl_delay", cyc_at(base + 4) - cyc_at(base + 2), 3);
    chk("rd8_rd_len", cyc_at(base + 5) - cyc_at(base + 4), 8);

    // idle auto-refresh
    wait_ws(W_AR, 3000, "auto_refresh");
    repeat (1400) tick();

    // refresh expires during a 256-word write; then wr, rd and refresh all pending
    sbase = svc_ws.size();
    wr_acks = 0;
    do_write(9'd256);
    wait_ws(W_TWR, 400, "defer_twr");
    chk("defer_wr_acks", wr_acks, 256);
    sdram_wr_burst = 9'd4;
    sdram_rd_burst = 9'd4;
    sdram_wr_req = 1'b1;
    sdram_rd_req = 1'b1;
    wait_ws(W_IDLE, 50, "defer_idle");
    tick();
    chk("defer_next_is_ar", 32'(work_state), 32'(W_AR));
    wr_acks = 0;
    rd_acks = 0;
    er_cnt = -1;
    for (int n = 0; n < 100 && !sdram_wr_ack; n++) tick();
    sdram_wr_req = 1'b0;
    for (int n = 0; n < 100 && !sdram_rd_ack; n++) tick();
    sdram_rd_req = 1'b0;
    wait_ws(W_IDLE, 100, "prio_done");
    chk("prio_svc0", 32'(svc_ws[sbase]), 32'(W_ACTIVE));
    chk("prio_svc1", (sbase + 1 < svc_ws.size()) ? 32'(svc_ws[sbase + 1]) : 32'hFFFF_FFFF, 32'(W_AR));
    chk("prio_svc2", (sbase + 2 < svc_ws.size()) ? 32'(svc_ws[sbase + 2]) : 32'hFFFF_FFFF, 32'(W_ACTIVE));
    chk("prio_svc2_rw", (sbase + 2 < svc_rw.size()) ? 32'(svc_rw[sbase + 2]) : 32'hFFFF_FFFF, 0);
    chk("prio_svc3", (sbase + 3 < svc_ws.size()) ? 32'(svc_ws[sbase + 3]) : 32'hFFFF_FFFF, 32'(W_ACTIVE));
    chk("prio_svc3_rw", (sbase + 3 < svc_rw.size()) ? 32'(svc_rw[sbase + 3]) : 32'hFFFF_FFFF, 1);
    chk("prio_wr4_acks", wr_acks, 4);
    chk("prio_rd4_acks", rd_acks, 4);
    chk("prio_rd4_end_rdburst_cnt", er_cnt, 0);

    // reset asserted in the middle of a write burst
    sdram_wr_burst = 9'd256;
    sdram_wr_req = 1'b1;
    wait_ws(W_WD, 50, "mid_wd");
    sdram_wr_req = 1'b0;
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (2) tick();
    run_init("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
